flag_cond_interlock: RTL and testbench
======================================

# flag_cond_interlock

Condition-evaluation and flag-interlock stage between the ID stage and the ID/EX pipeline register. It evaluates the 4-bit condition field of the instruction in ID against the N/Zero/C/V outputs of the status register. It tracks in-flight flag-setting instructions and stalls any conditional instruction that would otherwise read stale flags. It registers the EX-stage control bits, including the status-register load enable, so the flags update only for instructions that actually execute.

## Interface
- FLAG_LAT, 2: cycles from issue (ID→EX edge) to the edge at which the status register loads the new flags; legal range 1..8.

- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- IdValid  in  1  valid instruction present in ID
- IdCond  in  4  condition field (instr[31:28])
- IdSetFlags  in  1  S bit of the ID instruction
- Flush  in  1  kill the ID instruction this cycle (taken branch)
- HoldExt  in  1  downstream freeze; EX registers and counter hold
- N, Zero, C, V  in  1 each  current status-register outputs
- Stall  out  1  combinational; hold PC and IF/ID this cycle
- ExValid  out  1  registered; EX slot holds a real instruction
- ExExecute  out  1  registered; EX instruction passed its condition
- ExSetFlags  out  1  registered; drives the status-register Ld
- FlagsBusy  out  1  combinational; pending counter ≠ 0

## Operation
- Condition pass (combinational, from current N/Zero/C/V):
  - 0000 EQ Z
  - 0001 NE !Z
  - 0010 CS C
  - 0011 CC !C
  - 0100 MI N
  - 0101 PL !N
  - 0110 VS V
  - 0111 VC !V
  - 1000 HI C&!Z
  - 1001 LS !C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT !Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 NV 0
- Flag dependence: IdCond ∉ {1110, 1111}.
- Hazard = flag dependence & (cnt ≠ 0).
- Stall = IdValid & ~Flush & hazard.
- Issue = IdValid & ~Flush & ~hazard & ~HoldExt.
- Pending counter cnt, 3 bits, reset 0:
  - Issue & pass & IdSetFlags: cnt ← FLAG_LAT−1. Load wins over decrement.
  - Otherwise, if cnt ≠ 0 & ~HoldExt: cnt ← cnt−1.
  - HoldExt with no load: cnt holds.
- EX registers, updated on the rising edge:
  - HoldExt = 1: all hold.
  - Else if Issue: ExValid ← 1, ExExecute ← pass, ExSetFlags ← pass & IdSetFlags.
  - Else: insert a bubble (ExValid, ExExecute, ExSetFlags ← 0).
- A failed-condition instruction still issues with ExValid = 1, ExExecute = 0. It never loads cnt and never asserts ExSetFlags.
- Flush has priority over Stall: a flushed instruction never stalls, never issues, and never loads cnt.

## Timing
- Reset (Rst_n low, asynchronous): ExValid, ExExecute, ExSetFlags = 0 and cnt = 0, so Stall = 0 and FlagsBusy = 0. Takes effect immediately mid-operation; a pending interlock is discarded.
- Stall and FlagsBusy are combinational from the inputs and cnt, valid in the same cycle.
- EX outputs have a 1-cycle latency from the ID cycle in which Issue = 1.
- FLAG_LAT = 2: a conditional instruction directly behind a flag-setting instruction stalls exactly 1 cycle and then issues with the updated flags.
- FLAG_LAT = 1: cnt loads 0; no stall ever occurs.
- FLAG_LAT = N: a worst-case stall of N−1 cycles.
- HoldExt extends the stall window cycle-for-cycle, because the counter does not decrement while held.
- Back-to-back flag-setters: each issuing setter reloads cnt.

## Test plan
- Condition sweep: each of the 16 IdCond codes against all 16 N/Zero/C/V combinations, with cnt = 0 and IdValid = 1 -> ExExecute next cycle equals the table above; ExValid = 1 for every vector.
- FLAG_LAT=2, S-setting AL ADD issued at cycle t, then a BEQ in ID at t+1 -> Stall = 1 at t+1 only; BEQ issues at t+2; ExSetFlags = 1 at t+1; FlagsBusy = 1 at t+1.
- AL and NV instructions directly behind an S-setter -> Stall = 0, issue with no gap.
- Flush asserted on an S-setting instruction in ID -> next cycle ExValid = 0, cnt = 0; a following EQ does not stall.
- cnt = 1 with HoldExt = 1 for 3 cycles and a GT waiting in ID -> Stall = 1 for all 3 cycles plus 1; EX registers hold their values throughout.
- Rst_n pulled low while cnt = 1 and ExSetFlags = 1 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/flag_cond_interlock.sv
// Condition evaluation and status-flag interlock between the ID stage and the ID/EX register.
// Holds flag-dependent instructions in ID while a flag-setting instruction is still in flight.
module flag_cond_interlock #(
    parameter int unsigned FLAG_LAT = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       IdValid,
    input  logic [3:0] IdCond,
    input  logic       IdSetFlags,
    input  logic       Flush,
    input  logic       HoldExt,
    input  logic       N,
    input  logic       Zero,
    input  logic       C,
    input  logic       V,
    output logic       Stall,
    output logic       ExValid,
    output logic       ExExecute,
    output logic       ExSetFlags,
    output logic       FlagsBusy
);

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    // Value loaded on issue of a flag setter: edges still to wait before flags are visible.
    localparam logic [2:0] CNT_LOAD = 3'(FLAG_LAT - 1);

    cond_e      cond;
    logic       pass;
    logic       flag_dep;
    logic       hazard;
    logic       issue;
    logic       load;
    logic [2:0] cnt;

    assign cond = cond_e'(IdCond);

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = Zero;
            COND_NE: pass = ~Zero;
            COND_CS: pass = C;
            COND_CC: pass = ~C;
            COND_MI: pass = N;
            COND_PL: pass = ~N;
            COND_VS: pass = V;
            COND_VC: pass = ~V;
            COND_HI: pass = C & ~Zero;
            COND_LS: pass = ~C | Zero;
            COND_GE: pass = (N == V);
            COND_LT: pass = (N != V);
            COND_GT: pass = ~Zero & (N == V);
            COND_LE: pass = Zero | (N != V);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

    assign flag_dep  = (cond != COND_AL) && (cond != COND_NV);
    assign FlagsBusy = (cnt != 3'd0);
    assign hazard    = flag_dep & FlagsBusy;
    assign Stall     = IdValid & ~Flush & hazard;
    assign issue     = IdValid & ~Flush & ~hazard & ~HoldExt;
    assign load      = issue & pass & IdSetFlags;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= CNT_LOAD;
        end else if (FlagsBusy && !HoldExt) begin
            cnt <= cnt - 3'd1;
        end
    end

    // A failed-condition instruction still occupies the EX slot, but never executes or loads flags.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ExValid    <= 1'b0;
            ExExecute  <= 1'b0;
            ExSetFlags <= 1'b0;
        end else if (!HoldExt) begin
            ExValid    <= issue;
            ExExecute  <= issue & pass;
            ExSetFlags <= load;
        end
    end

endmodule

// File: tb/tb_flag_cond_interlock.sv
// Self-checking bench for flag_cond_interlock: per-cycle comparison against a behavioural
// model plus directed sequences with hand-computed expectations.
module tb_flag_cond_interlock;

    localparam int unsigned FLAG_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_cond = 4'hE;
    logic       id_set_flags = 1'b0;
    logic       flush = 1'b0;
    logic       hold_ext = 1'b0;
    logic       flag_n = 1'b0;
    logic       flag_z = 1'b0;
    logic       flag_c = 1'b0;
    logic       flag_v = 1'b0;
    logic       stall;
    logic       ex_valid;
    logic       ex_execute;
    logic       ex_set_flags;
    logic       flags_busy;

    int n_pass = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    flag_cond_interlock #(.FLAG_LAT(FLAG_LAT)) dut (
        .Clk(clk), .Rst_n(rst_n), .IdValid(id_valid), .IdCond(id_cond),
        .IdSetFlags(id_set_flags), .Flush(flush), .HoldExt(hold_ext),
        .N(flag_n), .Zero(flag_z), .C(flag_c), .V(flag_v),
        .Stall(stall), .ExValid(ex_valid), .ExExecute(ex_execute),
        .ExSetFlags(ex_set_flags), .FlagsBusy(flags_busy)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Condition rule: bits [3:1] pick a predicate, bit 0 inverts it (AL inverted gives NV).
    function automatic bit cond_holds(input logic [3:0] c, input logic n, input logic z,
                                      input logic cf, input logic v);
        bit base;
        base = 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            3'd7: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Behavioural model: cycles still to wait for fresh flags, and the EX slot contents.
    int  m_wait = 0;
    bit  m_valid = 1'b0;
    bit  m_exec = 1'b0;
    bit  m_sf = 1'b0;
    bit  m_pass;
    bit  m_dep;
    bit  m_issue;

    assign m_pass  = cond_holds(id_cond, flag_n, flag_z, flag_c, flag_v);
    assign m_dep   = (id_cond < 4'hE);
    assign m_issue = id_valid && !flush && !(m_dep && m_wait > 0) && !hold_ext;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait  <= 0;
            m_valid <= 1'b0;
            m_exec  <= 1'b0;
            m_sf    <= 1'b0;
        end else begin
            if (!hold_ext) begin
                m_valid <= m_issue;
                m_exec  <= m_issue && m_pass;
                m_sf    <= m_issue && m_pass && id_set_flags;
            end
            if (m_issue && m_pass && id_set_flags) m_wait <= int'(FLAG_LAT) - 1;
            else if (m_wait > 0 && !hold_ext)      m_wait <= m_wait - 1;
        end
    end

    always @(negedge clk) begin
        check("model_stall", stall, id_valid && !flush && m_dep && m_wait > 0);
        check("model_busy", flags_busy, m_wait > 0);
        check("model_ex_valid", ex_valid, m_valid);
        check("model_ex_execute", ex_execute, m_exec);
        check("model_ex_set_flags", ex_set_flags, m_sf);
    end

    // Advance to 2 time units after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic v, input logic [3:0] c, input logic s,
                       input logic f, input logic h);
        id_valid     = v;
        id_cond      = c;
        id_set_flags = s;
        flush        = f;
        hold_ext     = h;
    endtask

    task automatic set_flags(input logic [3:0] nzcv);
        flag_n = nzcv[3];
        flag_z = nzcv[2];
        flag_c = nzcv[1];
        flag_v = nzcv[0];
    endtask

    typedef struct {
        logic [3:0] cond;
        logic [3:0] nzcv;
        logic       exp;
    } pin_t;

    pin_t pins [12] = '{
        '{4'h0, 4'b0100, 1'b1},  // EQ, Z=1
        '{4'h1, 4'b0100, 1'b0},  // NE, Z=1
        '{4'h8, 4'b0110, 1'b0},  // HI, C=1 Z=1
        '{4'h8, 4'b0010, 1'b1},  // HI, C=1 Z=0
        '{4'h9, 4'b0000, 1'b1},  // LS, C=0
        '{4'hA, 4'b1001, 1'b1},  // GE, N=V=1
        '{4'hB, 4'b1000, 1'b1},  // LT, N=1 V=0
        '{4'hC, 4'b1001, 1'b1},  // GT, Z=0 N=V
        '{4'hD, 4'b0000, 1'b0},  // LE, Z=0 N=V
        '{4'hF, 4'b1111, 1'b0},  // NV
        '{4'h4, 4'b1000, 1'b1},  // MI, N=1
        '{4'h7, 4'b0001, 1'b0}   // VC, V=1
    };

    initial begin
        bit prev_exp;
        prev_exp = 1'b0;

        #2;
        check("reset_stall", stall, 1'b0);
        check("reset_busy", flags_busy, 1'b0);
        check("reset_ex_valid", ex_valid, 1'b0);
        check("reset_ex_execute", ex_execute, 1'b0);
        check("reset_ex_set_flags", ex_set_flags, 1'b0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Condition sweep: every code against every flag combination, no flag setters.
        for (int k = 0; k < 256; k++) begin
            next_cycle();
            if (k > 0) begin
                check("sweep_ex_execute", ex_execute, prev_exp);
                check("sweep_ex_valid", ex_valid, 1'b1);
            end
            put(1'b1, 4'(k / 16), 1'b0, 1'b0, 1'b0);
            set_flags(4'(k % 16));
            prev_exp = cond_holds(4'(k / 16), flag_n, flag_z, flag_c, flag_v);
        end
        next_cycle();
        check("sweep_ex_execute", ex_execute, prev_exp);

        // Hand-computed condition outcomes.
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                next_cycle();
                check("pin_ex_execute", ex_execute, pins[i-1].exp);
            end
            put(1'b1, pins[i].cond, 1'b0, 1'b0, 1'b0);
            set_flags(pins[i].nzcv);
        end
        next_cycle();
        check("pin_ex_execute", ex_execute, pins[11].exp);

        // S-setting AL followed by BEQ: one-cycle stall, then issue with updated flags.
        put(1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
        set_flags(4'b0000);
        #2;
        check("setter_stall", stall, 1'b0);
        check("setter_busy", flags_busy, 1'b0);
        next_cycle();
        check("setter_ex_set_flags", ex_set_flags, 1'b1);
        check("setter_ex_execute", ex_execute, 1'b1);
        put(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("beq_stall", stall, 1'b1);
        check("beq_busy", flags_busy, 1'b1);
        next_cycle();
        check("beq_bubble", ex_valid, 1'b0);
        set_flags(4'b0100);
        #2;
        check("beq_stall_released", stall, 1'b0);
        check("beq_busy_released", flags_busy, 1'b0);
        next_cycle();
        check("beq_ex_valid", ex_valid, 1'b1);
        check("beq_ex_execute", ex_execute, 1'b1);
        check("beq_ex_set_flags", ex_set_flags, 1'b0);

        // NV and AL behind a setter issue without a gap.
        put(1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
        set_flags(4'b0000);
        next_cycle();
        put(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        #2;
        check("nv_stall", stall, 1'b0);
        check("nv_busy", flags_busy, 1'b1);
        next_cycle();
        check("nv_ex_valid", ex_valid, 1'b1);
        check("nv_ex_execute", ex_execute, 1'b0);
        put(1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
        #2;
        check("al_stall", stall, 1'b0);
        next_cycle();
        check("al_ex_execute", ex_execute, 1'b1);

        // Flushed setter never issues and never arms the interlock.
        put(1'b1, 4'hE, 1'b1, 1'b1, 1'b0);
        #2;
        check("flush_stall", stall, 1'b0);
        next_cycle();
        check("flush_ex_valid", ex_valid, 1'b0);
        check("flush_busy", flags_busy, 1'b0);
        put(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        set_flags(4'b0100);
        #2;
        check("flush_eq_stall", stall, 1'b0);
        next_cycle();
        check("flush_eq_ex_execute", ex_execute, 1'b1);

        // HoldExt freezes the counter and EX registers while a GT waits.
        put(1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
        set_flags(4'b0000);
        for (int h = 0; h < 3; h++) begin
            next_cycle();
            check("hold_ex_valid", ex_valid, 1'b1);
            check("hold_ex_set_flags", ex_set_flags, 1'b1);
            put(1'b1, 4'hC, 1'b0, 1'b0, 1'b1);
            #2;
            check("hold_stall", stall, 1'b1);
        end
        next_cycle();
        check("hold_end_ex_set_flags", ex_set_flags, 1'b1);
        put(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        #2;
        check("hold_end_stall", stall, 1'b1);
        check("hold_end_busy", flags_busy, 1'b1);
        next_cycle();
        check("gt_bubble", ex_valid, 1'b0);
        #2;
        check("gt_stall_released", stall, 1'b0);
        next_cycle();
        check("gt_ex_valid", ex_valid, 1'b1);
        check("gt_ex_execute", ex_execute, 1'b1);
        check("gt_ex_set_flags", ex_set_flags, 1'b0);

        // Asynchronous reset mid-interlock.
        put(1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
        next_cycle();
        check("pre_reset_ex_set_flags", ex_set_flags, 1'b1);
        put(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("pre_reset_stall", stall, 1'b1);
        check("pre_reset_busy", flags_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #2;
        check("async_reset_stall", stall, 1'b0);
        check("async_reset_busy", flags_busy, 1'b0);
        check("async_reset_ex_valid", ex_valid, 1'b0);
        check("async_reset_ex_execute", ex_execute, 1'b0);
        check("async_reset_ex_set_flags", ex_set_flags, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        #2;
        check("post_reset_stall", stall, 1'b0);
        next_cycle();
        check("post_reset_ex_valid", ex_valid, 1'b1);
        put(1'b0, 4'hE, 1'b0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
